// File: rtl/riscv_main_control_if.sv
// Control bus between instruction decode and the main control decoder:
// opcode and update enable in, registered datapath strobes out.
interface riscv_main_control_if;
    localparam int unsigned OPW = 7;

    logic           en;
    logic [OPW-1:0] op_code;
    logic           alu_src;
    logic           mem_to_reg;
    logic           reg_write;
    logic           mem_read;
    logic           mem_write;
    logic           branch;
    logic [1:0]     alu_op;
    logic           illegal;

    // Decode stage side: presents the opcode, consumes the strobes
    modport master (
        output en, op_code,
        input  alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, alu_op, illegal
    );

    // Control decoder side
    modport slave (
        input  en, op_code,
        output alu_src, mem_to_reg, reg_write, mem_read, mem_write,
               branch, alu_op, illegal
    );
endinterface

// File: rtl/riscv_main_control.sv
// Main control decoder for the single-issue RISC-V datapath.
// Decodes the full 7-bit opcode into datapath strobes, registered with
// one cycle of latency; en=0 holds the previous strobes.
// Optional macro CONTROL_EXT_OPS_EN adds the I-type ALU opcode (ALUOp=11).
module riscv_main_control (
    input  logic                 clk,
    input  logic                 rst_n,
    riscv_main_control_if.slave  ctrl
);
    localparam int unsigned OPW = 7;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(7'b0110011);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(7'b0000011);
    localparam logic [OPW-1:0] OP_STORE = OPW'(7'b0100011);
    localparam logic [OPW-1:0] OP_BRNCH = OPW'(7'b1100011);
`ifdef CONTROL_EXT_OPS_EN
    localparam logic [OPW-1:0] OP_IMM   = OPW'(7'b0010011);
`endif

    logic       alu_src_c;
    logic       mem_to_reg_c;
    logic       reg_write_c;
    logic       mem_read_c;
    logic       mem_write_c;
    logic       branch_c;
    logic [1:0] alu_op_c;
    logic       illegal_c;

    // Full-opcode decode; unlisted opcodes leave every strobe low and flag illegal
    always_comb begin
        alu_src_c    = 1'b0;
        mem_to_reg_c = 1'b0;
        reg_write_c  = 1'b0;
        mem_read_c   = 1'b0;
        mem_write_c  = 1'b0;
        branch_c     = 1'b0;
        alu_op_c     = 2'b00;
        illegal_c    = 1'b0;
        case (ctrl.op_code)
            OP_RTYPE: begin
                reg_write_c = 1'b1;
                alu_op_c    = 2'b10;
            end
            OP_LOAD: begin
                alu_src_c    = 1'b1;
                mem_to_reg_c = 1'b1;
                reg_write_c  = 1'b1;
                mem_read_c   = 1'b1;
            end
            OP_STORE: begin
                alu_src_c   = 1'b1;
                mem_write_c = 1'b1;
            end
            OP_BRNCH: begin
                branch_c = 1'b1;
                alu_op_c = 2'b01;
            end
`ifdef CONTROL_EXT_OPS_EN
            OP_IMM: begin
                alu_src_c   = 1'b1;
                reg_write_c = 1'b1;
                alu_op_c    = 2'b11;
            end
`endif
            default: begin
                illegal_c = 1'b1;
            end
        endcase
    end

    // Output register: async clear, update only when enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl.alu_src    <= 1'b0;
            ctrl.mem_to_reg <= 1'b0;
            ctrl.reg_write  <= 1'b0;
            ctrl.mem_read   <= 1'b0;
            ctrl.mem_write  <= 1'b0;
            ctrl.branch     <= 1'b0;
            ctrl.alu_op     <= 2'b00;
            ctrl.illegal    <= 1'b0;
        end else if (ctrl.en) begin
            ctrl.alu_src    <= alu_src_c;
            ctrl.mem_to_reg <= mem_to_reg_c;
            ctrl.reg_write  <= reg_write_c;
            ctrl.mem_read   <= mem_read_c;
            ctrl.mem_write  <= mem_write_c;
            ctrl.branch     <= branch_c;
            ctrl.alu_op     <= alu_op_c;
            ctrl.illegal    <= illegal_c;
        end
    end
endmodule

// File: tb/tb_riscv_main_control.sv
// Scoreboard bench for riscv_main_control. Stimulus is applied 1 time unit
// after each rising edge; the expected strobes visible at the following
// falling edge are queued and checked by an independent monitor.
// Strobe vector order: {ALUSrc,MemToReg,RegWrite,MemRead,MemWrite,Branch,ALUOp[1:0],Illegal}
module tb_riscv_main_control;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    riscv_main_control_if bus ();

    riscv_main_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctrl  (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    logic [8:0] tbl [128];
    logic [8:0] exp_q [$];
    string      name_q [$];

    // Reference model state: what the registered strobes should be right now
    logic [8:0] st;
    logic       prev_rst;
    logic       prev_en;
    logic [6:0] prev_op;

    localparam logic [8:0] V_ILL = 9'b000000_00_1;

    // Decode table built straight from the opcode rows
    initial begin
        for (int i = 0; i < 128; i++) tbl[i] = V_ILL;
        tbl[7'b0110011] = 9'b001000_10_0;
        tbl[7'b0000011] = 9'b111100_00_0;
        tbl[7'b0100011] = 9'b100010_00_0;
        tbl[7'b1100011] = 9'b000001_01_0;
`ifdef CONTROL_EXT_OPS_EN
        tbl[7'b0010011] = 9'b101000_11_0;
`endif
    end

    function automatic logic [8:0] dut_vec();
        return {bus.alu_src, bus.mem_to_reg, bus.reg_write, bus.mem_read,
                bus.mem_write, bus.branch, bus.alu_op, bus.illegal};
    endfunction

    // One cycle of stimulus: wait for the edge, drive inputs, queue expectation
    task automatic cycle(input logic r, input logic e, input logic [6:0] op, input string nm);
        @(posedge clk);
        #1;
        if (!prev_rst)    st = '0;
        else if (prev_en) st = tbl[prev_op];
        rst_n       = r;
        bus.en      = e;
        bus.op_code = op;
        if (!r) st = '0;
        exp_q.push_back(st);
        name_q.push_back(nm);
        prev_rst = r;
        prev_en  = e;
        prev_op  = op;
    endtask

    // Monitor: pop one expectation per falling edge and compare, plus invariants
    initial begin
        logic [8:0] act;
        logic [8:0] ex;
        string      nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                ex  = exp_q.pop_front();
                nm  = name_q.pop_front();
                act = dut_vec();
                checks++;
                if (act !== ex) begin
                    failures++;
                    $display("FAIL %s: got %b want %b", nm, act, ex);
                end
                checks++;
                if (bus.mem_read && bus.mem_write) begin
                    failures++;
                    $display("FAIL %s inv_rd_wr: got %b want rd&wr=0", nm, act);
                end
                checks++;
                if (bus.branch && bus.reg_write) begin
                    failures++;
                    $display("FAIL %s inv_br_wr: got %b want br->!regwrite", nm, act);
                end
                checks++;
                if (bus.illegal && (bus.reg_write || bus.mem_read || bus.mem_write)) begin
                    failures++;
                    $display("FAIL %s inv_illegal: got %b want strobes 0", nm, act);
                end
`ifndef CONTROL_EXT_OPS_EN
                checks++;
                if (bus.alu_op === 2'b11) begin
                    failures++;
                    $display("FAIL %s inv_aluop11: got %b want alu_op!=11", nm, act);
                end
`endif
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    // Stimulus
    initial begin
        logic [6:0] legal [5];
        logic [6:0] op;
        logic       r;
        logic       e;
        legal[0] = 7'b0110011;
        legal[1] = 7'b0000011;
        legal[2] = 7'b0100011;
        legal[3] = 7'b1100011;
        legal[4] = 7'b0010011;

        rst_n       = 1'b0;
        bus.en      = 1'b1;
        bus.op_code = 7'b0110011;
        st       = '0;
        prev_rst = 1'b0;
        prev_en  = 1'b1;
        prev_op  = 7'b0110011;

        // Reset held with a legal opcode and clock running
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 7'b0110011, "reset_hold");

        // R-type then ld, each visible one cycle after presentation
        cycle(1'b1, 1'b1, 7'b0110011, "rtype_pre");
        cycle(1'b1, 1'b1, 7'b0000011, "rtype");
        cycle(1'b1, 1'b1, 7'b0100011, "ld");
        cycle(1'b1, 1'b1, 7'b1100011, "sd");
        cycle(1'b1, 1'b1, 7'b1100011, "beq");

        // Async reset mid-cycle after a valid decode
        cycle(1'b1, 1'b1, 7'b0000011, "pre_async");
        cycle(1'b1, 1'b1, 7'b0000011, "ld_async");
        cycle(1'b0, 1'b1, 7'b0000011, "async_clear");
        cycle(1'b1, 1'b1, 7'b0000011, "release");
        cycle(1'b1, 1'b1, 7'b0000011, "after_release");

        // Hold: en=0 with beq presented for three edges
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 7'b1100011, "hold_ld");
        cycle(1'b1, 1'b1, 7'b1100011, "hold_last");
        cycle(1'b1, 1'b1, 7'b1100011, "hold_release_beq");

        // Extension opcode, then full sweep of all opcodes
        cycle(1'b1, 1'b1, 7'b0010011, "pre_ext");
        cycle(1'b1, 1'b1, 7'b0000000, "ext_op");
        for (int i = 0; i < 128; i++) cycle(1'b1, 1'b1, 7'(i), "sweep");

        // Randomized traffic with enable gaps and occasional resets
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 39) != 0);
            e  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) < 7) op = legal[$urandom_range(0, 4)];
            else                          op = 7'($urandom_range(0, 127));
            cycle(r, e, op, "random");
        end

        cycle(1'b1, 1'b1, 7'b0110011, "flush");
        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/riscv_main_control.md
Name: riscv_main_control

Overview:
- Main control decoder for the single-issue RISC-V datapath.
- Decodes the 7-bit instruction opcode into the datapath control strobes: ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch and ALUOp.
- Outputs are registered, so they are valid one cycle after the opcode is presented.
- Sits between instruction fetch/decode and the ALU-control and datapath muxes.

Parameters:
- OPW, 7, opcode width; fixed at 7 for RV32/RV64.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- En  in  1  update enable; 0 holds all outputs.
- OpCode  in  7  instruction bits [6:0].
- ALUSrc  out  1  1 selects the immediate as ALU operand B.
- MemToReg  out  1  1 selects memory read data for writeback.
- RegWrite  out  1  register file write enable.
- MemRead  out  1  data memory read enable.
- MemWrite  out  1  data memory write enable.
- Branch  out  1  conditional branch instruction.
- ALUOp  out  2  ALU-control class code.
- Illegal  out  1  opcode not supported.

Behaviour:
- Reset (Rst_n=0, asynchronous, any time including mid-operation): every output goes to 0 immediately and stays 0 while Rst_n is low.
- Reset release is synchronous in effect: the first update happens on the first rising Clk edge with Rst_n=1 and En=1.
- On each rising Clk edge with En=1, all outputs register the combinational decode of OpCode. Latency is exactly 1 cycle.
- En=0: all outputs hold their previous values.
- Decode table, listed as ALUSrc, MemToReg, RegWrite, MemRead, MemWrite, Branch, ALUOp, Illegal:
  - R-type 0110011: 0 0 1 0 0 0 10 0
  - ld 0000011: 1 1 1 1 0 0 00 0
  - sd 0100011: 1 0 0 0 1 0 00 0
  - beq 1100011: 0 0 0 0 0 1 01 0
  - Any other opcode: all strobes 0, ALUOp=00, Illegal=1.
- Don't-care fields are driven to 0, e.g. MemToReg for sd and beq.
- Decode uses all 7 opcode bits. There is no partial or bit-subset matching.
- X or Z on OpCode is not required to resolve.
- Invariants, which must hold every cycle:
  - MemRead and MemWrite are never both 1.
  - Branch=1 implies RegWrite=0.
  - Illegal=1 implies every write/read strobe is 0.

Optional Feature:
- Macro: CONTROL_EXT_OPS_EN.
- When defined, I-type ALU opcode 0010011 decodes to 1 0 1 0 0 0 11 0 (immediate ALU op, RegWrite, no memory access). ALUOp=11 tells ALU control to use funct3 only.
- When undefined, 0010011 is illegal: all strobes 0, Illegal=1.
- ALUOp=11 is never produced when the macro is undefined.

Test Plan:
- Reset: hold Rst_n=0 with OpCode=0110011 and clock running -> all outputs 0. Then assert Rst_n=0 asynchronously mid-cycle after valid decode -> outputs clear before the next edge.
- R-type/ld sequence: OpCode=0110011, one edge -> 0,0,1,0,0,0,10,0. Then OpCode=0000011, one edge -> 1,1,1,1,0,0,00,0.
- sd/beq sequence: OpCode=0100011 -> 1,0,0,0,1,0,00,0. Then OpCode=1100011 -> 0,0,0,0,0,1,01,0. Each checked exactly one cycle after the change and not before.
- Hold: decode ld, set En=0, change OpCode to 1100011 for 3 edges -> outputs remain the ld values. Set En=1 -> beq values after one edge.
- Illegal sweep: all 128 opcodes -> only the four listed opcodes (five with CONTROL_EXT_OPS_EN) give Illegal=0. Invariants hold for every opcode.
- Extension: OpCode=0010011 -> with macro 1,0,1,0,0,0,11,0; without macro 0,0,0,0,0,0,00,1.
